// File: rtl/div_seq_param.sv
// Multi-cycle restoring divider: one quotient bit per clock, optional two's-complement
// mode, start/busy/done handshake and divide-by-zero flag. z = {quotient, remainder}.
module div_seq_param #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [2*WIDTH-1:0]   z
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FIXUP,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [CW-1:0]      count_reg, count_next;
  logic [WIDTH-1:0]   a_reg, a_next;
  logic [WIDTH-1:0]   q_reg, q_next;
  logic [WIDTH-1:0]   m_reg, m_next;
  logic [WIDTH-1:0]   op_q_reg, op_q_next;
  logic [WIDTH-1:0]   op_m_reg, op_m_next;
  logic               op_sgn_reg, op_sgn_next;
  logic               sq_reg, sq_next;
  logic               sm_reg, sm_next;
  logic               dz_reg, dz_next;
  logic [2*WIDTH-1:0] z_reg, z_next;
  logic               dbz_reg, dbz_next;

  // Operand sign flags and magnitudes, derived from the operands captured at start.
  logic             sgn;
  logic             op_q_neg, op_m_neg;
  logic [WIDTH-1:0] mag_q, mag_m;

  assign sgn      = op_sgn_reg & SIGNED_EN;
  assign op_q_neg = op_q_reg[WIDTH-1] & sgn;
  assign op_m_neg = op_m_reg[WIDTH-1] & sgn;
  assign mag_q    = op_q_neg ? (~op_q_reg + WIDTH'(1)) : op_q_reg;
  assign mag_m    = op_m_neg ? (~op_m_reg + WIDTH'(1)) : op_m_reg;

  // Partial remainder keeps the bit shifted out of A, so unsigned divisors above
  // 2^(WIDTH-1) still compare correctly.
  logic [WIDTH:0] part, trial;

  assign part  = {a_reg, q_reg[WIDTH-1]};
  assign trial = part - {1'b0, m_reg};

  // Final sign correction: conditional invert per bit, then add the negate flag.
  logic             neg_quot, neg_rem;
  logic [WIDTH-1:0] q_inv, a_inv;
  logic [WIDTH-1:0] quot, rem;

  assign neg_quot = sq_reg ^ sm_reg;
  assign neg_rem  = sq_reg;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cond_inv
      assign q_inv[gi] = q_reg[gi] ^ neg_quot;
      assign a_inv[gi] = a_reg[gi] ^ neg_rem;
    end
  endgenerate

  assign quot = q_inv + WIDTH'(neg_quot);
  assign rem  = a_inv + WIDTH'(neg_rem);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_reg  <= S_IDLE;
      count_reg  <= '0;
      a_reg      <= '0;
      q_reg      <= '0;
      m_reg      <= '0;
      op_q_reg   <= '0;
      op_m_reg   <= '0;
      op_sgn_reg <= 1'b0;
      sq_reg     <= 1'b0;
      sm_reg     <= 1'b0;
      dz_reg     <= 1'b0;
      z_reg      <= '0;
      dbz_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      a_reg      <= a_next;
      q_reg      <= q_next;
      m_reg      <= m_next;
      op_q_reg   <= op_q_next;
      op_m_reg   <= op_m_next;
      op_sgn_reg <= op_sgn_next;
      sq_reg     <= sq_next;
      sm_reg     <= sm_next;
      dz_reg     <= dz_next;
      z_reg      <= z_next;
      dbz_reg    <= dbz_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    a_next      = a_reg;
    q_next      = q_reg;
    m_next      = m_reg;
    op_q_next   = op_q_reg;
    op_m_next   = op_m_reg;
    op_sgn_next = op_sgn_reg;
    sq_next     = sq_reg;
    sm_next     = sm_reg;
    dz_next     = dz_reg;
    z_next      = z_reg;
    dbz_next    = dbz_reg;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          op_q_next   = dividend;
          op_m_next   = divisor;
          op_sgn_next = is_signed;
          dbz_next    = 1'b0;
          state_next  = S_LOAD;
        end
      end

      S_LOAD: begin
        sq_next    = op_q_neg;
        sm_next    = op_m_neg;
        q_next     = mag_q;
        m_next     = mag_m;
        a_next     = '0;
        count_next = CW'(WIDTH);
        dz_next    = (op_m_reg == '0);
        state_next = (op_m_reg == '0) ? S_FIXUP : S_RUN;
      end

      S_RUN: begin
        if (trial[WIDTH]) begin
          a_next = part[WIDTH-1:0];
        end else begin
          a_next = trial[WIDTH-1:0];
        end
        q_next     = {q_reg[WIDTH-2:0], ~trial[WIDTH]};
        count_next = count_reg - CW'(1);
        if (count_reg == CW'(1)) begin
          state_next = S_FIXUP;
        end
      end

      S_FIXUP: begin
        if (dz_reg) begin
          z_next = {{WIDTH{1'b1}}, op_q_reg};
        end else begin
          z_next = {quot, rem};
        end
        dbz_next   = dz_reg;
        state_next = S_DONE;
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy        = (state_reg == S_LOAD) || (state_reg == S_RUN) || (state_reg == S_FIXUP);
  assign done        = (state_reg == S_DONE);
  assign div_by_zero = dbz_reg;
  assign z           = z_reg;

endmodule

// File: tb/tb_div_seq_param.sv
// Directed plus randomized checks of div_seq_param (WIDTH=32) against a plain-arithmetic
// reference model: latency, result, flag, handshake and mid-operation reset.
module tb_div_seq_param;

  localparam int W = 32;

  logic          clock;
  logic          clear;
  logic          start;
  logic          is_signed;
  logic [W-1:0]  dividend;
  logic [W-1:0]  divisor;
  logic          busy;
  logic          done;
  logic          div_by_zero;
  logic [2*W-1:0] z;

  int vectors;
  int miscompares;

  div_seq_param #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clock       (clock),
    .clear       (clear),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .z           (z)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference: language division truncates toward zero, remainder takes the dividend sign.
  function automatic logic [63:0] ref_z(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    logic [31:0] uq, ur;
    if (b == 32'd0) return {32'hFFFF_FFFF, a};
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {q[31:0], r[31:0]};
    end
    uq = a / b;
    ur = a % b;
    return {uq, ur};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a clock edge; start is sampled on the next edge (edge 0).
  // glitch > 0 re-asserts start so that it is sampled at edge `glitch`.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s, input int glitch);
    logic [63:0] ez;
    logic        edz;
    int          elat;
    int          n;
    logic        got;
    ez   = ref_z(a, b, s);
    edz  = (b == 32'd0);
    elat = edz ? 2 : W + 2;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = 1'($urandom_range(0, 1));
    chk("busy_after_start", 64'(busy), 64'd1);
    n   = 0;
    got = 1'b0;
    while (!got && n < 100) begin
      start = (glitch > 0 && n + 1 == glitch);
      @(posedge clock);
      #1;
      start = 1'b0;
      n++;
      if (done) got = 1'b1;
    end
    chk("latency", 64'(n), 64'(elat));
    chk("z", z, ez);
    chk("div_by_zero", 64'(div_by_zero), 64'(edz));
    chk("busy_at_done", 64'(busy), 64'd0);
    @(posedge clock);
    #1;
    chk("done_one_cycle", 64'(done), 64'd0);
    chk("z_held", z, ez);
    $display("div a=%h b=%h signed=%0d -> z=%h dz=%0d lat=%0d", a, b, s, z, div_by_zero, n);
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rs;
    int          mode;
    logic        saw_done;

    vectors     = 0;
    miscompares = 0;
    clear       = 1'b0;
    start       = 1'b0;
    is_signed   = 1'b0;
    dividend    = '0;
    divisor     = '0;

    #3;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_dbz", 64'(div_by_zero), 64'd0);
    chk("reset_z", z, 64'd0);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;

    // Directed cases; consecutive calls also exercise back-to-back start after done.
    run_div(32'd100, 32'd7, 1'b0, 0);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    run_div(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    run_div(32'h1234_5678, 32'd0, 1'b0, 0);
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run_div(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 0);
    run_div(32'h8000_0000, 32'd0, 1'b1, 0);
    // Start pulsed again while busy must be ignored.
    run_div(32'd100, 32'd7, 1'b0, 5);

    for (int i = 0; i < 24; i++) begin
      ra   = $urandom;
      rs   = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 4);
      case (mode)
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'd0 - 32'($urandom_range(1, 15));
        3:       rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      if (rb == 32'd0 && mode != 0) rb = 32'd3;
      run_div(ra, rb, rs, 0);
    end

    // Asynchronous reset in the middle of a division.
    dividend  = 32'd1000;
    divisor   = 32'd3;
    is_signed = 1'b0;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    clear = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_z", z, 64'd0);
    chk("abort_dbz", 64'(div_by_zero), 64'd0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    clear    = 1'b1;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", 64'(saw_done), 64'd0);
    run_div(32'd1000, 32'd3, 1'b0, 0);
    run_div(32'hFFFF_FF9C, 32'd7, 1'b1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
